// File: rtl/npu_mmio_multiq.sv
// npu_mmio_multiq: AXI-Lite register block for NUM_CQ NPU command queues.
// Define NPU_MMIO_TIMESTAMP_EN to add the 64-bit TS_LO/TS_HI cycle counter.
module npu_mmio_multiq #(
  parameter int          NUM_CQ  = 4,
  parameter logic [31:0] VERSION = 32'h0001_0002,
  parameter int          ADDR_W  = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADDR_W-1:0]    s_axi_awaddr,
  input  logic                 s_axi_awvalid,
  output logic                 s_axi_awready,
  input  logic [31:0]          s_axi_wdata,
  input  logic [3:0]           s_axi_wstrb,
  input  logic                 s_axi_wvalid,
  output logic                 s_axi_wready,
  output logic [1:0]           s_axi_bresp,
  output logic                 s_axi_bvalid,
  input  logic                 s_axi_bready,
  input  logic [ADDR_W-1:0]    s_axi_araddr,
  input  logic                 s_axi_arvalid,
  output logic                 s_axi_arready,
  output logic [31:0]          s_axi_rdata,
  output logic [1:0]           s_axi_rresp,
  output logic                 s_axi_rvalid,
  input  logic                 s_axi_rready,
  output logic [NUM_CQ*64-1:0] cq_base,
  output logic [NUM_CQ*32-1:0] cq_size,
  output logic [NUM_CQ*32-1:0] cq_tail,
  output logic [NUM_CQ*32-1:0] cq_head,
  output logic [NUM_CQ-1:0]    cq_doorbell,
  input  logic                 head_upd_valid,
  input  logic [3:0]           head_upd_q,
  input  logic [31:0]          head_upd_val,
  input  logic                 event_valid,
  input  logic [3:0]           event_q,
  output logic                 irq
);

  localparam int QW = (NUM_CQ > 1) ? $clog2(NUM_CQ) : 1;
  localparam logic [15:0] QM = 16'((32'd1 << NUM_CQ) - 32'd1);
  localparam logic [31:0] VMASK = {QM, QM};
  localparam logic [4:0] NQ = 5'(NUM_CQ);
  localparam logic [ADDR_W-1:0] QBASE = ADDR_W'(32'h100);
  localparam logic [ADDR_W-1:0] QEND = ADDR_W'(32'h100 + NUM_CQ * 32);
  localparam logic [1:0] OKAY = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

`ifdef NPU_MMIO_TIMESTAMP_EN
  localparam bit TS_EN = 1'b1;
`else
  localparam bit TS_EN = 1'b0;
`endif

  typedef struct packed {
    logic          err;
    logic          glob;
    logic [2:0]    off;
    logic [QW-1:0] q;
  } dec_t;

  typedef enum logic [1:0] {W_IDLE, W_HALF, W_RESP} wstate_t;

  function automatic dec_t decode(input logic [ADDR_W-1:0] a);
    dec_t d;
    logic [ADDR_W-1:0] t;
    t = a - QBASE;
    d.glob = a < QBASE;
    d.q = t[5 +: QW];
    d.off = d.glob ? a[4:2] : t[4:2];
    if (d.glob)
      d.err = (|a[7:5]) || (!TS_EN && a[4:3] == 2'b11);
    else
      d.err = (a >= QEND) || (t[4:2] > 3'd5);
    return d;
  endfunction

  function automatic logic [31:0] bmerge(
    input logic [31:0] o,
    input logic [31:0] d,
    input logic [3:0]  s
  );
    for (int i = 0; i < 4; i++)
      if (s[i]) o[8*i +: 8] = d[8*i +: 8];
    return o;
  endfunction

  logic [31:0] base_lo [NUM_CQ];
  logic [31:0] base_hi [NUM_CQ];
  logic [31:0] sz [NUM_CQ];
  logic [31:0] tl [NUM_CQ];
  logic [31:0] hd [NUM_CQ];
  logic        enable;
  logic [31:0] irq_status, irq_enable, ist_n;
  logic [NUM_CQ-1:0] nonempty;

  wstate_t wst, wst_n;
  logic              aw_have, w_have;
  logic [ADDR_W-1:0] aw_q, wa;
  logic [31:0]       wd_q, wd, tail_new, smask;
  logic [3:0]        ws_q, ws;
  logic              aw_hs, w_hs, ar_hs, commit;
  logic              tail_bad, wr_ok, srst;
  dec_t              wdec, rdec;
  logic [31:0]       rd_val, hw_set;
  logic              hu_ok, ev_ok;
  logic [QW-1:0]     hq;

  assign s_axi_awready = !rst && wst != W_RESP && !aw_have;
  assign s_axi_wready  = !rst && wst != W_RESP && !w_have;
  assign s_axi_bvalid  = wst == W_RESP;
  assign s_axi_arready = !rst && !s_axi_rvalid;

  assign aw_hs = s_axi_awvalid && s_axi_awready;
  assign w_hs  = s_axi_wvalid && s_axi_wready;
  assign ar_hs = s_axi_arvalid && s_axi_arready;
  assign commit = wst != W_RESP && (aw_have || aw_hs) && (w_have || w_hs);

  assign wa = aw_have ? aw_q : s_axi_awaddr;
  assign wd = w_have ? wd_q : s_axi_wdata;
  assign ws = w_have ? ws_q : s_axi_wstrb;
  assign smask = {{8{ws[3]}}, {8{ws[2]}}, {8{ws[1]}}, {8{ws[0]}}};
  assign wdec = decode(wa);
  assign rdec = decode(s_axi_araddr);

  assign tail_new = bmerge(tl[wdec.q], wd, ws);
  assign tail_bad = !wdec.glob && wdec.off == 3'd4 && tail_new >= sz[wdec.q];
  assign wr_ok = commit && !wdec.err && !tail_bad;
  assign srst = wr_ok && wdec.glob && wdec.off == 3'd3 && ws[0] && wd[1];

  assign hq = head_upd_q[QW-1:0];
  assign hu_ok = head_upd_valid && {1'b0, head_upd_q} < NQ;
  assign ev_ok = event_valid && {1'b0, event_q} < NQ;

  for (genvar g = 0; g < NUM_CQ; g++) begin : g_out
    assign cq_base[g*64 +: 64] = {base_hi[g], base_lo[g]};
    assign cq_size[g*32 +: 32] = sz[g];
    assign cq_tail[g*32 +: 32] = tl[g];
    assign cq_head[g*32 +: 32] = hd[g];
  end

  // Write channel state register
  always_ff @(posedge clk) begin
    if (rst) wst <= W_IDLE;
    else     wst <= wst_n;
  end

  // Write channel next state: wait for both halves, then hold the response
  always_comb begin
    wst_n = wst;
    unique case (wst)
      W_IDLE, W_HALF: begin
        if (commit)              wst_n = W_RESP;
        else if (aw_hs || w_hs)  wst_n = W_HALF;
      end
      W_RESP:  if (s_axi_bready) wst_n = W_IDLE;
      default: wst_n = W_IDLE;
    endcase
  end

  // Latch AW and W halves independently; capture the response at commit
  always_ff @(posedge clk) begin
    if (rst) begin
      aw_have <= 1'b0;
      w_have <= 1'b0;
      aw_q <= '0;
      wd_q <= '0;
      ws_q <= '0;
      s_axi_bresp <= OKAY;
    end else if (commit) begin
      aw_have <= 1'b0;
      w_have <= 1'b0;
      s_axi_bresp <= wr_ok ? OKAY : SLVERR;
    end else begin
      if (aw_hs) begin
        aw_have <= 1'b1;
        aw_q <= s_axi_awaddr;
      end
      if (w_hs) begin
        w_have <= 1'b1;
        wd_q <= s_axi_wdata;
        ws_q <= s_axi_wstrb;
      end
    end
  end

  // Per-queue non-empty flags
  always_comb begin
    nonempty = '0;
    for (int i = 0; i < NUM_CQ; i++) nonempty[i] = hd[i] != tl[i];
  end

  // IRQ status next value: soft reset or W1C first, hardware sets override
  always_comb begin
    hw_set = 32'(hu_ok && head_upd_val == tl[hq]) << head_upd_q;
    hw_set = hw_set | (32'(ev_ok) << (5'd16 + {1'b0, event_q}));
    ist_n = irq_status;
    if (srst)
      ist_n = '0;
    else if (wr_ok && wdec.glob && wdec.off == 3'd4)
      ist_n = irq_status & ~(wd & smask);
    ist_n = (ist_n | hw_set) & VMASK;
  end

  // Register file, doorbell pulses and registered irq
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CQ; i++) begin
        base_lo[i] <= '0;
        base_hi[i] <= '0;
        sz[i] <= '0;
        tl[i] <= '0;
        hd[i] <= '0;
      end
      enable <= 1'b0;
      irq_status <= '0;
      irq_enable <= '0;
      cq_doorbell <= '0;
      irq <= 1'b0;
    end else begin
      cq_doorbell <= '0;
      irq_status <= ist_n;
      irq <= |(irq_status & irq_enable);
      if (wr_ok && wdec.glob) begin
        if (wdec.off == 3'd3 && ws[0]) enable <= wd[0];
        if (wdec.off == 3'd5) irq_enable <= bmerge(irq_enable, wd, ws);
      end
      if (srst)
        for (int i = 0; i < NUM_CQ; i++) begin
          tl[i] <= '0;
          hd[i] <= '0;
        end
      if (wr_ok && !wdec.glob) begin
        case (wdec.off)
          3'd0: base_lo[wdec.q] <= bmerge(base_lo[wdec.q], wd, ws);
          3'd1: base_hi[wdec.q] <= bmerge(base_hi[wdec.q], wd, ws);
          3'd2: sz[wdec.q] <= bmerge(sz[wdec.q], wd, ws);
          3'd4: tl[wdec.q] <= tail_new;
          3'd5: if (enable) cq_doorbell <= NUM_CQ'(1) << wdec.q;
          default: ;
        endcase
      end
      if (hu_ok) hd[hq] <= head_upd_val;
    end
  end

`ifdef NPU_MMIO_TIMESTAMP_EN
  logic [63:0] ts;
  logic [31:0] ts_snap;

  // Free-running counter; TS_LO read freezes the high word for TS_HI
  always_ff @(posedge clk) begin
    if (rst) begin
      ts <= '0;
      ts_snap <= '0;
    end else begin
      ts <= ts + 64'd1;
      if (ar_hs && !rdec.err && rdec.glob && rdec.off == 3'd6)
        ts_snap <= ts[63:32];
    end
  end
`endif

  // Read data mux
  always_comb begin
    rd_val = '0;
    if (!rdec.err) begin
      if (rdec.glob) begin
        case (rdec.off)
          3'd0: rd_val = VERSION;
          3'd1: rd_val = {16'h0, 8'd32, 8'(NUM_CQ)};
          3'd2: rd_val = 32'(nonempty);
          3'd3: rd_val = {31'b0, enable};
          3'd4: rd_val = irq_status;
          3'd5: rd_val = irq_enable;
`ifdef NPU_MMIO_TIMESTAMP_EN
          3'd6: rd_val = ts[31:0];
          3'd7: rd_val = ts_snap;
`endif
          default: rd_val = '0;
        endcase
      end else begin
        case (rdec.off)
          3'd0: rd_val = base_lo[rdec.q];
          3'd1: rd_val = base_hi[rdec.q];
          3'd2: rd_val = sz[rdec.q];
          3'd3: rd_val = hd[rdec.q];
          3'd4: rd_val = tl[rdec.q];
          default: rd_val = '0;
        endcase
      end
    end
  end

  // Read channel: one outstanding read, data held until rready
  always_ff @(posedge clk) begin
    if (rst) begin
      s_axi_rvalid <= 1'b0;
      s_axi_rdata <= '0;
      s_axi_rresp <= OKAY;
    end else if (ar_hs) begin
      s_axi_rvalid <= 1'b1;
      s_axi_rdata <= rd_val;
      s_axi_rresp <= rdec.err ? SLVERR : OKAY;
    end else if (s_axi_rvalid && s_axi_rready) begin
      s_axi_rvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_npu_mmio_multiq.sv
// tb_npu_mmio_multiq: directed and random checks of npu_mmio_multiq
// against a register-level reference model.
module tb_npu_mmio_multiq;

  localparam int NQ = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [11:0] awaddr, araddr;
  logic awvalid, awready, wvalid, wready, bvalid, bready;
  logic arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0] wstrb;
  logic [1:0] bresp, rresp;
  logic [NQ*64-1:0] cq_base;
  logic [NQ*32-1:0] cq_size, cq_tail, cq_head;
  logic [NQ-1:0] cq_doorbell;
  logic hu_valid, ev_valid, irq;
  logic [3:0] hu_q, ev_q;
  logic [31:0] hu_val;

  npu_mmio_multiq dut (
    .clk(clk), .rst(rst),
    .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid),
    .s_axi_wready(wready), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid),
    .s_axi_bready(bready), .s_axi_araddr(araddr), .s_axi_arvalid(arvalid),
    .s_axi_arready(arready), .s_axi_rdata(rdata), .s_axi_rresp(rresp),
    .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .cq_base(cq_base), .cq_size(cq_size), .cq_tail(cq_tail),
    .cq_head(cq_head), .cq_doorbell(cq_doorbell),
    .head_upd_valid(hu_valid), .head_upd_q(hu_q), .head_upd_val(hu_val),
    .event_valid(ev_valid), .event_q(ev_q), .irq(irq)
  );

`ifdef NPU_MMIO_TIMESTAMP_EN
  localparam bit TS_MAP = 1'b1;
`else
  localparam bit TS_MAP = 1'b0;
`endif

  int passed = 0;
  int total = 0;
  int db_cnt[NQ];
  int exp_db[NQ];

  logic [31:0] m_blo[NQ], m_bhi[NQ], m_size[NQ], m_tail[NQ], m_head[NQ];
  logic m_en;
  logic [31:0] m_ist, m_ien;

  // count doorbell cycles per queue; a correct pulse counts exactly once
  always @(negedge clk)
    for (int i = 0; i < NQ; i++)
      if (rst) db_cnt[i] = 0;
      else if (cq_doorbell[i]) db_cnt[i] = db_cnt[i] + 1;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mrg(input logic [31:0] o,
                                      input logic [31:0] d,
                                      input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  task automatic m_write(input logic [11:0] a, input logic [31:0] d,
                         input logic [3:0] s, output logic [1:0] r);
    int q, off;
    logic [31:0] nt, bm;
    r = 2'b00;
    bm = mrg(32'h0, 32'hFFFF_FFFF, s);
    if (a < 12'h100) begin
      case (a[7:0] & 8'hFC)
        8'h00, 8'h04, 8'h08: ;
        8'h0C: if (s[0]) begin
          m_en = d[0];
          if (d[1]) begin
            for (int i = 0; i < NQ; i++) begin
              m_tail[i] = 0;
              m_head[i] = 0;
            end
            m_ist = 0;
          end
        end
        8'h10: m_ist = m_ist & ~(d & bm);
        8'h14: m_ien = mrg(m_ien, d, s);
        8'h18, 8'h1C: r = TS_MAP ? 2'b00 : 2'b10;
        default: r = 2'b10;
      endcase
    end else begin
      q = (int'(a) - 256) / 32;
      off = (int'(a) - 256) % 32 / 4;
      if (q >= NQ) r = 2'b10;
      else case (off)
        0: m_blo[q] = mrg(m_blo[q], d, s);
        1: m_bhi[q] = mrg(m_bhi[q], d, s);
        2: m_size[q] = mrg(m_size[q], d, s);
        3: ;
        4: begin
          nt = mrg(m_tail[q], d, s);
          if (nt >= m_size[q]) r = 2'b10;
          else m_tail[q] = nt;
        end
        5: if (m_en) exp_db[q]++;
        default: r = 2'b10;
      endcase
    end
  endtask

  task automatic m_read(input logic [11:0] a, output logic [31:0] d,
                        output logic [1:0] r);
    int q, off;
    d = 0;
    r = 2'b00;
    if (a < 12'h100) begin
      case (a[7:0] & 8'hFC)
        8'h00: d = 32'h0001_0002;
        8'h04: d = 32'h0000_2004;
        8'h08: for (int i = 0; i < NQ; i++) d[i] = m_head[i] != m_tail[i];
        8'h0C: d = {31'b0, m_en};
        8'h10: d = m_ist;
        8'h14: d = m_ien;
        default: r = 2'b10;
      endcase
    end else begin
      q = (int'(a) - 256) / 32;
      off = (int'(a) - 256) % 32 / 4;
      if (q >= NQ) r = 2'b10;
      else case (off)
        0: d = m_blo[q];
        1: d = m_bhi[q];
        2: d = m_size[q];
        3: d = m_head[q];
        4: d = m_tail[q];
        5: d = 0;
        default: r = 2'b10;
      endcase
    end
  endtask

  task automatic axi_write(input logic [11:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic [1:0] resp);
    int n;
    logic ah, wh;
    @(negedge clk);
    awaddr = a; awvalid = 1; wdata = d; wstrb = s; wvalid = 1;
    n = 0;
    while ((awvalid || wvalid) && n < 50) begin
      ah = awvalid && awready;
      wh = wvalid && wready;
      @(negedge clk);
      if (ah) awvalid = 0;
      if (wh) wvalid = 0;
      n++;
    end
    check("wr_addr_timeout", 64'(n >= 50), 0);
    awvalid = 0; wvalid = 0; bready = 1;
    n = 0;
    while (!bvalid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("wr_resp_timeout", 64'(n >= 50), 0);
    resp = bresp;
    @(negedge clk);
    bready = 0;
  endtask

  task automatic axi_read(input logic [11:0] a, output logic [31:0] d,
                          output logic [1:0] resp);
    int n;
    logic go;
    @(negedge clk);
    araddr = a; arvalid = 1;
    n = 0;
    go = 0;
    while (!go && n < 50) begin
      go = arready;
      @(negedge clk);
      n++;
    end
    arvalid = 0; rready = 1;
    n = 0;
    while (!rvalid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("rd_timeout", 64'(n >= 50), 0);
    d = rdata;
    resp = rresp;
    @(negedge clk);
    rready = 0;
  endtask

  task automatic do_write(input logic [11:0] a, input logic [31:0] d,
                          input logic [3:0] s);
    logic [1:0] r, er;
    axi_write(a, d, s, r);
    m_write(a, d, s, er);
    check($sformatf("bresp@%0h", a), r, er);
  endtask

  task automatic do_read(input logic [11:0] a);
    logic [31:0] d, ed;
    logic [1:0] r, er;
    axi_read(a, d, r);
    m_read(a, ed, er);
    check($sformatf("rdata@%0h", a), d, ed);
    check($sformatf("rresp@%0h", a), r, er);
  endtask

  task automatic head_upd(input logic [3:0] q, input logic [31:0] v);
    @(negedge clk);
    hu_valid = 1; hu_q = q; hu_val = v;
    @(negedge clk);
    hu_valid = 0;
    if (q < NQ) begin
      m_head[q] = v;
      if (v == m_tail[q]) m_ist[q] = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic fire_event(input logic [3:0] q);
    @(negedge clk);
    ev_valid = 1; ev_q = q;
    @(negedge clk);
    ev_valid = 0;
    m_ist[16 + q] = 1'b1;
    @(negedge clk);
  endtask

  function automatic logic [11:0] raddr();
    logic [11:0] a;
    int k;
    do begin
      k = $urandom_range(0, 9);
      if (k < 3) a = 12'($urandom_range(0, 7) * 4);
      else if (k < 9)
        a = 12'(256 + $urandom_range(0, 5) * 32 + $urandom_range(0, 7) * 4);
      else a = 12'($urandom_range(0, 4095));
    end while (TS_MAP && a >= 12'h18 && a < 12'h20);
    return a;
  endfunction

  initial begin
    logic [31:0] d;
    logic [1:0] r;
    logic ok;
    int n;
    awaddr = 0; awvalid = 0; wdata = 0; wstrb = 0; wvalid = 0; bready = 0;
    araddr = 0; arvalid = 0; rready = 0;
    hu_valid = 0; hu_q = 0; hu_val = 0; ev_valid = 0; ev_q = 0;
    for (int i = 0; i < NQ; i++) begin
      m_blo[i] = 0; m_bhi[i] = 0; m_size[i] = 0;
      m_tail[i] = 0; m_head[i] = 0; exp_db[i] = 0;
    end
    m_en = 0; m_ist = 0; m_ien = 0;

    repeat (3) @(negedge clk);
    check("rst_awready", awready, 0);
    check("rst_wready", wready, 0);
    check("rst_arready", arready, 0);
    check("rst_bvalid", bvalid, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_bresp", bresp, 0);
    check("rst_rresp", rresp, 0);
    check("rst_irq", irq, 0);
    check("rst_doorbell", cq_doorbell, 0);
    check("rst_tail", cq_tail[63:0], 0);
    check("rst_base", cq_base[63:0], 0);
    rst = 0;
    @(negedge clk);
    check("idle_awready", awready, 1);
    check("idle_arready", arready, 1);

    axi_read(12'h000, d, r);
    check("version", d, 32'h0001_0002);
    check("version_resp", r, 0);
    axi_read(12'h004, d, r);
    check("caps", d, 32'h0000_2004);

    do_write(12'h00C, 32'h1, 4'hF);
    do_write(12'h148, 32'h1000, 4'hF);
    do_write(12'h150, 32'h40, 4'hF);
    do_write(12'h154, 32'hDEAD, 4'hF);
    repeat (2) @(negedge clk);
    check("q2_tail_out", cq_tail[2*32 +: 32], 32'h40);
    check("q2_db_count", db_cnt[2], 1);
    check("q0_db_count", db_cnt[0], 0);
    check("q3_db_count", db_cnt[3], 0);

    do_write(12'h014, 32'h4, 4'hF);
    @(negedge clk);
    hu_valid = 1; hu_q = 2; hu_val = 32'h40;
    @(negedge clk);
    hu_valid = 0;
    m_head[2] = 32'h40; m_ist[2] = 1'b1;
    check("irq_latency", irq, 0);
    @(negedge clk);
    check("irq_set", irq, 1);
    do_read(12'h010);
    do_read(12'h008);
    do_write(12'h010, 32'h4, 4'hF);
    check("irq_clr", irq, 0);

    fire_event(1);
    @(negedge clk);
    awaddr = 12'h010; awvalid = 1; wdata = 32'h0002_0000; wstrb = 4'hF;
    wvalid = 1; ev_valid = 1; ev_q = 1;
    check("w1c_rdy", {awready, wready}, 2'b11);
    @(negedge clk);
    awvalid = 0; wvalid = 0; ev_valid = 0; bready = 1;
    n = 0;
    while (!bvalid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("w1c_bvalid", bvalid, 1);
    @(negedge clk);
    bready = 0;
    m_write(12'h010, 32'h0002_0000, 4'hF, r);
    m_ist[17] = 1'b1;
    axi_read(12'h010, d, r);
    check("set_wins_bit17", d[17], 1);

    do_write(12'h150, 32'h1000, 4'hF);
    check("tail_oob_resp", bresp, 2'b10);
    do_read(12'h150);
    do_write(12'h1A0, 32'h1234, 4'hF);
    check("q5_wr_resp", bresp, 2'b10);
    do_read(12'h1A0);
    do_read(12'h018);

    @(negedge clk);
    wdata = 32'h0; wstrb = 4'hF; wvalid = 1;
    check("early_wready", wready, 1);
    @(negedge clk);
    wvalid = 0;
    repeat (2) @(negedge clk);
    check("half_bvalid", bvalid, 0);
    awaddr = 12'h154; awvalid = 1;
    check("late_awready", awready, 1);
    @(negedge clk);
    awvalid = 0;
    exp_db[2]++;
    awaddr = 12'h150; wdata = 32'h10; awvalid = 1; wvalid = 1;
    ok = 1;
    for (int i = 0; i < 5; i++) begin
      if (!bvalid || awready || wready) ok = 0;
      @(negedge clk);
    end
    check("bvalid_hold", ok, 1);
    awvalid = 0; wvalid = 0; bready = 1;
    check("hold_bresp", bresp, 0);
    @(negedge clk);
    bready = 0;
    check("b_done", bvalid, 0);
    check("db_single", db_cnt[2], 2);
    do_read(12'h150);

    for (int it = 0; it < 300; it++) begin
      int op;
      logic [11:0] a;
      logic [31:0] v;
      op = $urandom_range(0, 9);
      if (op < 4) begin
        a = raddr();
        v = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 'h2000));
        if (a == 12'h00C)
          v = ($urandom_range(0, 7) == 0) ? 32'h3 : 32'($urandom_range(0, 1));
        do_write(a, v, 4'($urandom_range(0, 15)));
      end else if (op < 7) begin
        do_read(raddr());
      end else if (op < 9) begin
        n = $urandom_range(0, 7);
        v = $urandom_range(0, 1) ? m_tail[n % NQ] : 32'($urandom_range(0, 'h2000));
        head_upd(4'(n), v);
      end else begin
        fire_event(4'($urandom_range(0, NQ - 1)));
      end
      check("irq_track", irq, 64'(|(m_ist & m_ien)));
    end

    repeat (2) @(negedge clk);
    for (int q = 0; q < NQ; q++) begin
      check("base_out", cq_base[q*64 +: 64], {m_bhi[q], m_blo[q]});
      check("size_out", cq_size[q*32 +: 32], m_size[q]);
      check("tail_out", cq_tail[q*32 +: 32], m_tail[q]);
      check("head_out", cq_head[q*32 +: 32], m_head[q]);
      check("db_total", db_cnt[q], exp_db[q]);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/npu_mmio_multiq.md
# npu_mmio_multiq

AXI-Lite MMIO register block for the NPU host interface, generalised from one command queue to `NUM_CQ` independent queues. It holds per-queue ring configuration (base, size, head, tail) and issues one-cycle doorbell pulses to the queue fetch engine. It aggregates per-queue CQ_EMPTY and EVENT interrupts into one `irq` line with write-1-to-clear status. It sits between the host AXI-Lite port and the CQ fetch/DMA engines inside `npu_top_axi`.

## Interface
- `NUM_CQ`, 4: number of command queues, 1..16.
- `VERSION`, 32'h0001_0002: value returned at VERSION.
- `ADDR_W`, 12: significant AXI-Lite address bits; upper bits are ignored.
- `clk` in 1: the single clock.
- `rst` in 1: synchronous, active-high reset.
- `s_axi_awaddr/awvalid/awready`, `s_axi_wdata/wstrb/wvalid/wready`, `s_axi_bresp/bvalid/bready`: AXI-Lite write channels, 32-bit data, 4-bit strobe.
- `s_axi_araddr/arvalid/arready`, `s_axi_rdata/rresp/rvalid/rready`: AXI-Lite read channels, 32-bit data.
- `cq_base` out NUM_CQ*64: ring base per queue.
- `cq_size` out NUM_CQ*32: ring size in bytes.
- `cq_tail` out NUM_CQ*32: current tail per queue.
- `cq_head` out NUM_CQ*32: current head per queue.
- `cq_doorbell` out NUM_CQ: one-cycle doorbell pulse per queue.
- `head_upd_valid` in 1, `head_upd_q` in 4, `head_upd_val` in 32: engine-side head update.
- `event_valid` in 1, `event_q` in 4: engine completion event.
- `irq` out 1: `|(IRQ_STATUS & IRQ_ENABLE)`, registered.

## Operation
- Global registers:
  - 0x00 VERSION (RO).
  - 0x04 CAPS (RO): `{16'h0, 8'd32, NUM_CQ[7:0]}`.
  - 0x08 STATUS (RO): bit q = queue q non-empty.
  - 0x0C CONTROL: bit0 enable; bit1 soft-reset, self-clearing.
  - 0x10 IRQ_STATUS (W1C): bit q = CQ_EMPTY[q], bit 16+q = EVENT[q].
  - 0x14 IRQ_ENABLE (RW).
- Per-queue window at 0x100 + q*0x20:
  - +0x00 BASE_LO, +0x04 BASE_HI, +0x08 SIZE (RW).
  - +0x0C HEAD (RO).
  - +0x10 TAIL (RW).
  - +0x14 DOORBELL (WO; reads return 0).
- Byte strobes apply to all RW registers.
- Unmapped address or queue index ≥ NUM_CQ:
  - Write returns SLVERR and changes no state.
  - Read returns 0 with SLVERR.
- TAIL write with value ≥ SIZE: SLVERR; TAIL is unchanged.
- Any DOORBELL write (data ignored) with CONTROL.enable=1 produces a `cq_doorbell[q]` pulse. With enable=0 the write is ignored and returns OKAY.
- Head update: `head_upd_valid` loads HEAD[q]. If the new HEAD equals TAIL[q], CQ_EMPTY[q] is set. Updates with q ≥ NUM_CQ are dropped.
- `event_valid` sets EVENT[event_q].
- If a hardware set and a host W1C hit the same bit in the same cycle, set wins.
- Soft reset clears all HEAD, TAIL and IRQ_STATUS. BASE, SIZE, ENABLE and CONTROL.enable are kept.
- Write channel state machine W_IDLE → W_HALF → W_RESP:
  - AW and W are accepted independently, each latched once.
  - Commit happens when both are held.
  - Only one write is outstanding.
- Read channel: one outstanding read. `arready` is low while `rvalid` is high.

## Timing
- Reset: all ready, valid, `irq` and `cq_doorbell` signals are 0; all registers are 0; `bresp` and `rresp` are 0.
- Read: AR handshake at edge N. `rvalid` and `rdata` are valid from N+1 and held until `rready`.
- Write:
  - Commit occurs on the edge where the second of AW and W is accepted.
  - `bvalid` is high from the next cycle until `bready`.
  - `awready` and `wready` are low while `bvalid` is high.
- Doorbell: `cq_doorbell[q]` is high for exactly one cycle, the cycle after commit.
- IRQ: `irq` follows the status/enable change with one cycle of latency.
- Head update and host HEAD read in the same cycle: the read returns the old value.
- Reset mid-transaction: the pending AW, W, B and R are discarded; every channel returns to its reset value the cycle after `rst`.

## Configuration
- `NPU_MMIO_TIMESTAMP_EN` defined:
  - Adds a 64-bit free-running cycle counter, cleared by `rst`.
  - 0x18 TS_LO returns the low word and snapshots the high word in the same cycle.
  - 0x1C TS_HI returns the snapshot.
- Undefined: 0x18 and 0x1C are unmapped (SLVERR), and the counter logic is absent.

## Test plan
- Read 0x00 and 0x04 with NUM_CQ=4 → 32'h0001_0002 and 32'h0000_2004, OKAY.
- CONTROL=1, Q2 SIZE=0x1000, TAIL=0x40, DOORBELL write → `cq_tail[2]`=0x40; `cq_doorbell[2]` single pulse; other bits 0.
- IRQ_ENABLE=0x4, then `head_upd` q=2, val=0x40 → IRQ_STATUS bit2=1 and `irq`=1 next cycle; W1C 0x4 → `irq`=0.
- W1C of bit 17 in the same cycle as `event_valid` with q=1 → bit17 stays 1.
- TAIL write 0x1000 with SIZE=0x1000 → SLVERR, TAIL unchanged. Write to 0x1A0 (queue 5) → SLVERR.
- W presented 3 cycles before AW, with `bready` held low for 5 cycles → single commit; `bvalid` held; no second write accepted meanwhile.
